// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with ready/valid load and a per-bit consume enable.
// state | meaning:  IDLE = no word held, SR is zero  |  SHIFT = Q carries a valid bit, CNT bits remain
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] PD,
  input  logic             PV,
  output logic             PR,
  input  logic             E,
  output logic             Q,
  output logic             QV,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             load;

  // Last bit is being consumed this cycle; the slot is free for a new word.
  assign last_bit = (state_q == SHIFT) && E && (cnt_q == CW'(1));
  assign PR       = (state_q == IDLE) || last_bit;
  assign load     = PV && PR;

  assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  assign Q    = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign QV   = (state_q == SHIFT);
  assign DONE = done_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = last_bit;
    if (load) begin
      sr_d    = PD;
      cnt_d   = CW'(WIDTH);
      state_d = SHIFT;
    end else if ((state_q == SHIFT) && E) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q - CW'(1);
      if (last_bit) state_d = IDLE;
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: one MSB-first and one LSB-first instance share all inputs.
module tb_piso_serializer;

  logic       C = 1'b0;
  logic       R, PV, E;
  logic [7:0] PD;
  logic       q_m, qv_m, pr_m, done_m;
  logic       q_l, qv_l, pr_l, done_l;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .C(C), .R(R), .PD(PD), .PV(PV), .PR(pr_m), .E(E), .Q(q_m), .QV(qv_m), .DONE(done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .C(C), .R(R), .PD(PD), .PV(PV), .PR(pr_l), .E(E), .Q(q_l), .QV(qv_l), .DONE(done_l)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_bit(input logic [7:0] w, input int i, input logic exp_done);
    logic [7:0] wv;
    wv = w;
    chk($sformatf("q_msb w=%02h i=%0d", w, i), 32'(q_m), 32'(wv[7-i]));
    chk($sformatf("q_lsb w=%02h i=%0d", w, i), 32'(q_l), 32'(wv[i]));
    chk("qv_msb", 32'(qv_m), 32'd1);
    chk("qv_lsb", 32'(qv_l), 32'd1);
    chk("done_msb", 32'(done_m), 32'(exp_done));
    chk("done_lsb", 32'(done_l), 32'(exp_done));
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, " q_msb"}, 32'(q_m), 32'd0);
    chk({tag, " q_lsb"}, 32'(q_l), 32'd0);
    chk({tag, " qv"}, 32'(qv_m | qv_l), 32'd0);
    chk({tag, " pr"}, 32'(pr_m & pr_l), 32'd1);
    chk({tag, " done_msb"}, 32'(done_m), 32'(exp_done));
    chk({tag, " done_lsb"}, 32'(done_l), 32'(exp_done));
  endtask

  task automatic load(input logic [7:0] w);
    PD = w;
    PV = 1'b1;
    settle();
    chk("pr_before_load", 32'(pr_m & pr_l), 32'd1);
    step();
    PV = 1'b0;
  endtask

  task automatic bits(input logic [7:0] w, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      E = 1'b1;
      settle();
      chk_bit(w, i, 1'b0);
      chk($sformatf("pr_msb i=%0d", i), 32'(pr_m), 32'(i == 7));
      chk($sformatf("pr_lsb i=%0d", i), 32'(pr_l), 32'(i == 7));
      step();
    end
  endtask

  task automatic finish_word();
    settle();
    chk_idle("after_word", 1'b1);
    step();
    settle();
    chk_idle("idle_after_done", 1'b0);
  endtask

  initial begin
    R = 1'b1; PV = 1'b0; E = 1'b0; PD = 8'h00;
    #2;
    chk_idle("in_reset", 1'b0);
    step();
    R = 1'b0;
    E = 1'b1;
    settle();
    chk_idle("idle_e_ignored", 1'b0);
    step();
    chk_idle("idle_still", 1'b0);

    // Basic word, E always high
    load(8'hA5);
    bits(8'hA5, 0, 7);
    finish_word();

    load(8'h01);
    bits(8'h01, 0, 7);
    finish_word();

    // Stall: 3 bits, E low for 3 cycles, then the remaining 5
    load(8'hF0);
    bits(8'hF0, 0, 2);
    for (int s = 0; s < 3; s++) begin
      E = 1'b0;
      settle();
      chk_bit(8'hF0, 3, 1'b0);
      chk("pr_stall", 32'(pr_m | pr_l), 32'd0);
      step();
    end
    bits(8'hF0, 3, 7);
    finish_word();

    // Back-to-back FF then 00 with PV held
    load(8'hFF);
    PV = 1'b1;
    bits(8'hFF, 0, 6);
    E = 1'b1;
    PD = 8'h00;
    settle();
    chk_bit(8'hFF, 7, 1'b0);
    chk("pr_b2b", 32'(pr_m & pr_l), 32'd1);
    step();
    PV = 1'b0;
    settle();
    chk_bit(8'h00, 0, 1'b1);
    step();
    bits(8'h00, 1, 7);
    finish_word();

    // Reset mid-word after the 4th bit
    load(8'hC3);
    bits(8'hC3, 0, 3);
    settle();
    R = 1'b1;
    #1;
    chk_idle("async_reset", 1'b0);
    step();
    R = 1'b0;
    settle();
    chk_idle("post_reset", 1'b0);
    load(8'h81);
    bits(8'h81, 0, 7);
    finish_word();

    // PV with changing PD while PR low must not disturb the word
    load(8'h3C);
    for (int i = 0; i < 8; i++) begin
      E  = 1'b1;
      PV = (i != 7);
      PD = 8'($urandom);
      settle();
      chk_bit(8'h3C, i, 1'b0);
      chk("pr_noise", 32'(pr_m), 32'(i == 7));
      step();
    end
    PV = 1'b0;
    finish_word();

    // PD sampled only at the load edge
    load(8'h96);
    PD = 8'hFF;
    bits(8'h96, 0, 7);
    finish_word();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
